spi_cmd_ctrl: RTL and testbench
===============================

# spi_cmd_ctrl

Frame-level command controller that sits behind the byte-wide SPI receiver. It consumes the receiver's byte strobe stream plus the raw chip-select, and parses each chip-select frame as opcode, address, data. It issues single-cycle register-write strobes with an auto-incrementing address, and reports frame completion and protocol errors to the board-level status logic.

## Interface

Parameters:
- AW, 8, register address width; address wraps modulo 2^AW
- MAX_BURST, 16, maximum data bytes written per frame (1..255)

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- spi_ss  in  1  raw SPI chip-select, active-low, asynchronous to clk
- byte_vld  in  1  one-cycle strobe from SPI receiver, byte available
- byte_data  in  8  received byte, valid when byte_vld=1
- reg_we  out  1  one-cycle register write strobe
- reg_addr  out  AW  write address, valid with reg_we
- reg_wdata  out  8  write data, valid with reg_we
- start_o  out  1  one-cycle start pulse (START opcode)
- busy  out  1  high while a frame is open (state != IDLE)
- frame_done  out  1  one-cycle pulse at every frame close, good or bad
- err_o  out  1  one-cycle error pulse
- err_code  out  2  1=bad opcode, 2=short frame, 3=burst overflow; holds last code until next error
- err_cnt  out  8  saturating error count

## Operation

- spi_ss synchronised through 2 flops (ss_s1, ss_s2), plus an ss_s3 delay flop for edge detection. frame_open = ss_s3 & ~ss_s2 (falling). frame_close = ~ss_s3 & ss_s2 (rising).
- States: IDLE, CMD, ADDR, DATA, SKIP.
- IDLE: frame_open -> CMD. byte_vld is ignored.
- CMD, on byte_vld:
  - 0x02 (WRITE) -> ADDR.
  - 0x0B (START): pulse start_o -> SKIP.
  - Any other value: err code 1 -> SKIP.
- ADDR, on byte_vld: load addr_q <= byte_data[AW-1:0], clear burst counter -> DATA. If AW>8, upper bits are zero.
- DATA, on byte_vld:
  - If burst_cnt < MAX_BURST: reg_we=1, reg_addr=addr_q, reg_wdata=byte_data; addr_q <= addr_q+1 (wraps 2^AW-1 -> 0); burst_cnt++.
  - Otherwise: err code 3 (once per frame) -> SKIP. The byte is not written.
- SKIP: bytes discarded.
- frame_close in any non-IDLE state -> IDLE and pulse frame_done.
  - Closing from CMD with no byte received is a silent empty frame: frame_done only, no error.
  - Closing from ADDR, or from DATA with burst_cnt=0 after WRITE, raises err code 2.
- byte_vld and frame_close in the same cycle: the byte is processed first (write, error, start), then the state goes to IDLE. Any error from that byte takes priority over short-frame. Only one err_o pulse per cycle.
- frame_open while not IDLE is impossible after sync; if it occurs, it is ignored.
- err_cnt increments on each err_o and saturates at 255.
- Reset, any state: state=IDLE. All outputs 0: reg_we, start_o, busy, frame_done, err_o, err_code, err_cnt, reg_addr, reg_wdata. Sync flops = 1 (deselected). addr_q=0, burst_cnt=0.

## Timing

- All outputs are registered.
- reg_we, start_o, err_o (bad opcode/overflow) assert exactly 1 cycle after the byte_vld cycle. reg_addr and reg_wdata are held until the next write.
- frame_close is detected 3 clk after spi_ss rises at the pin. frame_done and short-frame err_o assert 1 cycle after the frame_close cycle.
- busy rises 1 cycle after frame_open and falls 1 cycle after frame_close.
- Back-to-back byte_vld on consecutive cycles must be accepted with no loss. The block never stalls: there is no backpressure.
- Mid-frame reset: outputs clear the next cycle. The block then waits for a fresh frame_open, so a frame already in progress is ignored until chip-select deasserts and re-asserts.

## Test plan

- WRITE burst: frame bytes 0x02,0x10,0xAA,0xBB,0xCC -> reg_we pulses at addr 0x10/0x11/0x12 with data 0xAA/0xBB/0xCC; frame_done once; err_cnt=0.
- Address wrap: 0x02,0xFF,0x01,0x02 (AW=8) -> writes at 0xFF then 0x00.
- Overflow: MAX_BURST=4, frame 0x02,0x00 followed by 6 data bytes -> 4 writes (addr 0..3); one err_o with code 3; frame_done once; err_cnt=1.
- Bad opcode and START: frame 0x55,0x01 -> err code 1, no writes. Frame 0x0B,0x99 -> one start_o pulse, no error.
- Short frame: frame 0x02,0x20 only -> no writes; err code 2 one cycle after frame_close. Empty frame (ss low/high, no bytes) -> frame_done only.
- Corner timing: last data byte_vld coincides with frame_close -> byte written, then IDLE. Reset asserted mid-burst -> all outputs 0 next cycle; the next full frame behaves normally.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
// Frame-level SPI command controller: parses opcode/address/data per chip-select
// frame, issues auto-incrementing register writes and reports frame status/errors.
module spi_cmd_ctrl #(
    parameter int AW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          spi_ss,
    input  logic          byte_vld,
    input  logic [7:0]    byte_data,
    output logic          reg_we,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          start_o,
    output logic          busy,
    output logic          frame_done,
    output logic          err_o,
    output logic [1:0]    err_code,
    output logic [7:0]    err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_SKIP
    } state_t;

    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_START  = 8'h0B;
    localparam logic [7:0] LP_MAX    = 8'(MAX_BURST);
    localparam logic [1:0] ERR_OPC   = 2'd1;
    localparam logic [1:0] ERR_SHORT = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    logic          r_ss_s1, r_ss_s2, r_ss_s3;
    logic          r_seen, r_armed;
    state_t        r_state;
    logic [AW-1:0] r_addr_q;
    logic [7:0]    r_burst_cnt;

    logic          r_reg_we;
    logic [AW-1:0] r_reg_addr;
    logic [7:0]    r_reg_wdata;
    logic          r_start;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [1:0]    r_err_code;
    logic [7:0]    r_err_cnt;

    logic          w_frame_open, w_frame_close;
    logic          w_room;
    state_t        w_state_post;
    logic          w_post_cnt0;
    state_t        w_state_next;
    logic          w_we, w_start, w_err, w_done;
    logic [1:0]    w_err_code;

    // r_armed requires chip-select to be seen high after reset, so a frame
    // already in progress when reset released is ignored until it re-opens.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ss_s1 <= 1'b1;
            r_ss_s2 <= 1'b1;
            r_ss_s3 <= 1'b1;
            r_seen  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_ss_s1 <= spi_ss;
            r_ss_s2 <= r_ss_s1;
            r_ss_s3 <= r_ss_s2;
            r_seen  <= 1'b1;
            r_armed <= r_armed | (r_seen & r_ss_s1);
        end
    end

    assign w_frame_open  = r_ss_s3 & ~r_ss_s2;
    assign w_frame_close = ~r_ss_s3 & r_ss_s2;
    assign w_room        = (r_burst_cnt < LP_MAX);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // w_state_post is the state after consuming this cycle's byte; a
    // coincident frame_close is applied on top of it.
    always_comb begin
        w_state_post = r_state;
        w_post_cnt0  = (r_burst_cnt == 8'd0);
        if (byte_vld) begin
            case (r_state)
                S_CMD:   w_state_post = (byte_data == OP_WRITE) ? S_ADDR : S_SKIP;
                S_ADDR: begin
                    w_state_post = S_DATA;
                    w_post_cnt0  = 1'b1;
                end
                S_DATA: begin
                    if (w_room) w_post_cnt0  = 1'b0;
                    else        w_state_post = S_SKIP;
                end
                default: ;
            endcase
        end
        w_state_next = w_state_post;
        if (r_state == S_IDLE) begin
            w_state_next = (w_frame_open && r_armed) ? S_CMD : S_IDLE;
        end else if (w_frame_close) begin
            w_state_next = S_IDLE;
        end
    end

    // Byte-driven errors win over short-frame, giving one err_o per cycle.
    always_comb begin
        w_we       = 1'b0;
        w_start    = 1'b0;
        w_err      = 1'b0;
        w_err_code = 2'd0;
        w_done     = 1'b0;
        if (byte_vld) begin
            case (r_state)
                S_CMD: begin
                    if (byte_data == OP_START) begin
                        w_start = 1'b1;
                    end else if (byte_data != OP_WRITE) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_OPC;
                    end
                end
                S_DATA: begin
                    if (w_room) begin
                        w_we = 1'b1;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = ERR_OVF;
                    end
                end
                default: ;
            endcase
        end
        if ((r_state != S_IDLE) && w_frame_close) begin
            w_done = 1'b1;
            if (!w_err && ((w_state_post == S_ADDR) ||
                           ((w_state_post == S_DATA) && w_post_cnt0))) begin
                w_err      = 1'b1;
                w_err_code = ERR_SHORT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr_q    <= '0;
            r_burst_cnt <= 8'd0;
        end else if ((r_state == S_ADDR) && byte_vld) begin
            r_addr_q    <= AW'(byte_data);
            r_burst_cnt <= 8'd0;
        end else if (w_we) begin
            r_addr_q    <= r_addr_q + AW'(1);
            r_burst_cnt <= r_burst_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_reg_we    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'd0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_reg_we <= w_we;
            r_start  <= w_start;
            r_busy   <= (w_state_next != S_IDLE);
            r_done   <= w_done;
            r_err    <= w_err;
            if (w_we) begin
                r_reg_addr  <= r_addr_q;
                r_reg_wdata <= byte_data;
            end
            if (w_err) begin
                r_err_code <= w_err_code;
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign reg_we     = r_reg_we;
    assign reg_addr   = r_reg_addr;
    assign reg_wdata  = r_reg_wdata;
    assign start_o    = r_start;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign err_o      = r_err;
    assign err_code   = r_err_code;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl: table vectors, reset corner case and random frames
// checked against a frame-level reference model.
module tb_spi_cmd_ctrl;

    localparam int AW   = 8;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          spi_ss = 1'b1;
    logic          byte_vld = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          reg_we;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          start_o;
    logic          busy;
    logic          frame_done;
    logic          err_o;
    logic [1:0]    err_code;
    logic [7:0]    err_cnt;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(.AW(AW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rstn(rstn), .spi_ss(spi_ss), .byte_vld(byte_vld),
        .byte_data(byte_data), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .start_o(start_o), .busy(busy),
        .frame_done(frame_done), .err_o(err_o), .err_code(err_code),
        .err_cnt(err_cnt)
    );

    typedef struct {
        logic [79:0] b;
        int          n;
        bit          coinc;
        int          nwr;
        logic [7:0]  af;
        logic [7:0]  al;
        logic [7:0]  dl;
        int          start;
        int          err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [15:0] obs_wr_q[$];
    int          obs_err_q[$];
    int          obs_start;
    int          obs_done;
    logic [15:0] exp_wr_q[$];
    int          exp_start;
    int          exp_err;
    logic [7:0]  frame_q[$];
    int          tally;
    int          last_code;

    always @(negedge clk) begin
        if (rstn) begin
            if (reg_we)     obs_wr_q.push_back({reg_addr, reg_wdata});
            if (start_o)    obs_start++;
            if (err_o)      obs_err_q.push_back(int'(err_code));
            if (frame_done) obs_done++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_wr_q.delete();
        obs_err_q.delete();
        obs_start = 0;
        obs_done  = 0;
    endtask

    task automatic note_err(input int code);
        if (code != 0) begin
            tally     = (tally < 255) ? tally + 1 : 255;
            last_code = code;
        end
    endtask

    // Frame rules: opcode, then (for WRITE) start address and up to MAXB data bytes.
    function automatic void model();
        int n = frame_q.size();
        int ndata;
        exp_wr_q.delete();
        exp_start = 0;
        exp_err   = 0;
        if (n == 0) return;
        if (frame_q[0] == 8'h0B) begin
            exp_start = 1;
        end else if (frame_q[0] != 8'h02) begin
            exp_err = 1;
        end else if (n == 1) begin
            exp_err = 2;
        end else begin
            ndata = n - 2;
            for (int i = 0; i < ndata && i < MAXB; i++)
                exp_wr_q.push_back({8'((int'(frame_q[1]) + i) % 256), frame_q[2+i]});
            if (ndata > MAXB)    exp_err = 3;
            else if (ndata == 0) exp_err = 2;
        end
    endfunction

    // Drives one chip-select frame; with coinc the last byte lands on frame_close.
    task automatic run_frame(input bit coinc, input int gapmax);
        int n = frame_q.size();
        spi_ss = 1'b0;
        repeat (4) tick();
        chk("busy_open", int'(busy), 1);
        for (int i = 0; i < n; i++) begin
            if (coinc && i == n - 3) spi_ss = 1'b1;
            byte_vld  = 1'b1;
            byte_data = frame_q[i];
            tick();
            byte_vld = 1'b0;
            if (!coinc) repeat ($urandom_range(0, gapmax)) tick();
        end
        byte_vld = 1'b0;
        spi_ss   = 1'b1;
        repeat (7) tick();
        chk("busy_idle", int'(busy), 0);
    endtask

    task automatic compare_model(input string tag);
        model();
        chk({tag, "_nwr"}, obs_wr_q.size(), exp_wr_q.size());
        for (int i = 0; i < exp_wr_q.size() && i < obs_wr_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), int'(obs_wr_q[i]), int'(exp_wr_q[i]));
        chk({tag, "_start"}, obs_start, exp_start);
        chk({tag, "_nerr"}, obs_err_q.size(), (exp_err != 0) ? 1 : 0);
        if (exp_err != 0 && obs_err_q.size() > 0)
            chk({tag, "_code"}, obs_err_q[0], exp_err);
        chk({tag, "_done"}, obs_done, 1);
        note_err(exp_err);
        chk({tag, "_errcnt"}, int'(err_cnt), tally);
        chk({tag, "_errcode"}, int'(err_code), last_code);
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{80'h0210AABBCC0000000000, 5, 1'b0, 3, 8'h10, 8'h12, 8'hCC, 0, 0};
        tbl[1]  = '{80'h02FF0102000000000000, 4, 1'b0, 2, 8'hFF, 8'h00, 8'h02, 0, 0};
        tbl[2]  = '{80'h02001122334455660000, 8, 1'b0, 4, 8'h00, 8'h03, 8'h44, 0, 3};
        tbl[3]  = '{80'h55010000000000000000, 2, 1'b0, 0, 8'h00, 8'h00, 8'h00, 0, 1};
        tbl[4]  = '{80'h0B990000000000000000, 2, 1'b0, 0, 8'h00, 8'h00, 8'h00, 1, 0};
        tbl[5]  = '{80'h02200000000000000000, 2, 1'b0, 0, 8'h00, 8'h00, 8'h00, 0, 2};
        tbl[6]  = '{80'h00000000000000000000, 0, 1'b0, 0, 8'h00, 8'h00, 8'h00, 0, 0};
        tbl[7]  = '{80'h02301122000000000000, 4, 1'b1, 2, 8'h30, 8'h31, 8'h22, 0, 0};
        tbl[8]  = '{80'h02000000000000000000, 1, 1'b0, 0, 8'h00, 8'h00, 8'h00, 0, 2};
        tbl[9]  = '{80'h02407700000000000000, 3, 1'b1, 1, 8'h40, 8'h40, 8'h77, 0, 0};
        tbl[10] = '{80'h02000102030405000000, 7, 1'b1, 4, 8'h00, 8'h03, 8'h04, 0, 3};
        tbl[11] = '{80'h0B010200000000000000, 3, 1'b1, 0, 8'h00, 8'h00, 8'h00, 1, 0};

        tally     = 0;
        last_code = 0;
        clear_obs();

        repeat (3) tick();
        chk("rst_reg_we", int'(reg_we), 0);
        chk("rst_start", int'(start_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_reg_addr", int'(reg_addr), 0);
        chk("rst_reg_wdata", int'(reg_wdata), 0);
        rstn = 1'b1;
        repeat (3) tick();

        foreach (tbl[k]) begin
            frame_q.delete();
            for (int i = 0; i < tbl[k].n; i++) frame_q.push_back(tbl[k].b[79-8*i -: 8]);
            clear_obs();
            run_frame(tbl[k].coinc, 1);
            chk($sformatf("v%0d_nwr", k), obs_wr_q.size(), tbl[k].nwr);
            if (tbl[k].nwr > 0 && obs_wr_q.size() > 0) begin
                chk($sformatf("v%0d_addr_first", k), int'(obs_wr_q[0][15:8]), int'(tbl[k].af));
                chk($sformatf("v%0d_addr_last", k), int'(obs_wr_q[$][15:8]), int'(tbl[k].al));
                chk($sformatf("v%0d_data_last", k), int'(obs_wr_q[$][7:0]), int'(tbl[k].dl));
                chk($sformatf("v%0d_addr_held", k), int'(reg_addr), int'(tbl[k].al));
                chk($sformatf("v%0d_data_held", k), int'(reg_wdata), int'(tbl[k].dl));
            end
            chk($sformatf("v%0d_start", k), obs_start, tbl[k].start);
            chk($sformatf("v%0d_nerr", k), obs_err_q.size(), (tbl[k].err != 0) ? 1 : 0);
            if (tbl[k].err != 0 && obs_err_q.size() > 0)
                chk($sformatf("v%0d_code", k), obs_err_q[0], tbl[k].err);
            chk($sformatf("v%0d_done", k), obs_done, 1);
            note_err(tbl[k].err);
            chk($sformatf("v%0d_errcnt", k), int'(err_cnt), tally);
            chk($sformatf("v%0d_errcode", k), int'(err_code), last_code);
        end

        // Reset in the middle of a burst, with chip-select held low afterwards.
        spi_ss = 1'b0;
        repeat (4) tick();
        frame_q = '{8'h02, 8'h10, 8'hAA};
        foreach (frame_q[i]) begin
            byte_vld  = 1'b1;
            byte_data = frame_q[i];
            tick();
        end
        byte_vld = 1'b0;
        chk("mid_we_before_rst", int'(reg_we), 1);
        rstn = 1'b0;
        tick();
        chk("mid_rst_reg_we", int'(reg_we), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_reg_addr", int'(reg_addr), 0);
        chk("mid_rst_reg_wdata", int'(reg_wdata), 0);
        chk("mid_rst_err_cnt", int'(err_cnt), 0);
        chk("mid_rst_err_code", int'(err_code), 0);
        rstn = 1'b1;
        tally     = 0;
        last_code = 0;
        clear_obs();
        frame_q = '{8'hBB, 8'hCC, 8'h02, 8'h05, 8'h01, 8'h02};
        foreach (frame_q[i]) begin
            byte_vld  = 1'b1;
            byte_data = frame_q[i];
            tick();
            byte_vld = 1'b0;
            tick();
        end
        chk("mid_ignored_busy", int'(busy), 0);
        spi_ss = 1'b1;
        repeat (7) tick();
        chk("mid_ignored_nwr", obs_wr_q.size(), 0);
        chk("mid_ignored_done", obs_done, 0);
        chk("mid_ignored_nerr", obs_err_q.size(), 0);
        frame_q = '{8'h02, 8'h70, 8'h5A};
        clear_obs();
        run_frame(1'b0, 0);
        compare_model("post_rst");

        for (int f = 0; f < 40; f++) begin
            int sel, n;
            bit coinc;
            frame_q.delete();
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                n = 0;
            end else if (sel < 12) begin
                n = $urandom_range(1, 9);
                frame_q.push_back(8'h02);
            end else if (sel < 16) begin
                n = $urandom_range(1, 3);
                frame_q.push_back(8'h0B);
            end else begin
                n = $urandom_range(1, 3);
                frame_q.push_back(8'($urandom_range(0, 255)));
            end
            for (int i = 1; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
            coinc = (n >= 3) && ($urandom_range(0, 1) == 1);
            clear_obs();
            run_frame(coinc, coinc ? 0 : $urandom_range(0, 2));
            compare_model($sformatf("rnd%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
